// File: rtl/ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_stage_pkg
//  Description : Shared constants for the execute operand stage, the ALU and
//                the decoder (opcode encodings, default widths, zero register)
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_operand_stage_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned RA_W_DEF  = 5;
  localparam int unsigned ALU_OP_W  = 3;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 3'd0;
  localparam alu_op_t ALU_SUB  = 3'd1;
  localparam alu_op_t ALU_AND  = 3'd2;
  localparam alu_op_t ALU_OR   = 3'd3;
  localparam alu_op_t ALU_SRL  = 3'd4;
  localparam alu_op_t ALU_SRA  = 3'd5;
  localparam alu_op_t ALU_SGTU = 3'd6;
  localparam alu_op_t ALU_SGT  = 3'd7;

  // Register address 0 always reads as zero and is never written.
  localparam int unsigned ZERO_REG = 0;

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Operand bypass selector. Zero register wins, then the MEM
//                stage result, then the WB stage result, then register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RA_W  = RA_W_DEF
) (
  input  logic [RA_W-1:0]  addr_i,
  input  logic [WIDTH-1:0] rf_data_i,
  input  logic             m_we_i,
  input  logic [RA_W-1:0]  m_addr_i,
  input  logic [WIDTH-1:0] m_data_i,
  input  logic             w_we_i,
  input  logic [RA_W-1:0]  w_addr_i,
  input  logic [WIDTH-1:0] w_data_i,
  output logic [WIDTH-1:0] data_o
);

  // Priority select: the younger MEM result shadows the older WB result.
  always_comb begin
    data_o = rf_data_i;
    if (addr_i == RA_W'(ZERO_REG)) begin
      data_o = '0;
    end else if (m_we_i && (m_addr_i == addr_i)) begin
      data_o = m_data_i;
    end else if (w_we_i && (w_addr_i == addr_i)) begin
      data_o = w_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_stage
//  Description : ID/EX pipeline register feeding the ALU. Resolves bypassing
//                at capture, selects immediate for B, valid/ready on both
//                sides, flush, and a saturating backpressure counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RA_W  = RA_W_DEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic [2:0]       id_alu_op,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             id_we,
  input  logic             m_we,
  input  logic [RA_W-1:0]  m_addr,
  input  logic [WIDTH-1:0] m_data,
  input  logic             w_we,
  input  logic [RA_W-1:0]  w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       ALUOp,
  output logic [RA_W-1:0]  ex_dst,
  output logic             ex_we,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_t          op_q, op_d;
  logic [RA_W-1:0]  dst_q, dst_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] w_fwd_rs;
  logic [WIDTH-1:0] w_fwd_rt;

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rs (
    .addr_i   (id_rs),
    .rf_data_i(id_rd1),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_data_i (m_data),
    .w_we_i   (w_we),
    .w_addr_i (w_addr),
    .w_data_i (w_data),
    .data_o   (w_fwd_rs)
  );

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rt (
    .addr_i   (id_rt),
    .rf_data_i(id_rd2),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_data_i (m_data),
    .w_we_i   (w_we),
    .w_addr_i (w_addr),
    .w_data_i (w_data),
    .data_o   (w_fwd_rt)
  );

  // The slot is free when empty or being drained; flush deliberately not included.
  assign id_ready = !valid_q || ex_ready;

  // Next entry: flush clears, a free slot captures or bubbles, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    dst_d   = dst_q;
    we_d    = we_q;
    if (flush || (id_ready && !id_valid)) begin
      valid_d = 1'b0;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      dst_d   = '0;
      we_d    = 1'b0;
    end else if (id_ready) begin
      valid_d = 1'b1;
      a_d     = w_fwd_rs;
      b_d     = id_use_imm ? id_imm : w_fwd_rt;
      op_d    = id_alu_op;
      dst_d   = id_dst;
      we_d    = id_we && (id_dst != RA_W'(ZERO_REG));
    end
  end

  // Count stalled cycles, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !ex_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline register and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid  = valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign ALUOp     = op_q;
  assign ex_dst    = dst_q;
  assign ex_we     = we_q;
  assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_operand_stage
//  Description : Self-checking bench for ex_operand_stage: directed scenarios
//                followed by random traffic against a cycle reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset, flush, id_valid, id_ready;
  logic [4:0]  id_rs, id_rt, id_dst, m_addr, w_addr, ex_dst;
  logic [31:0] id_rd1, id_rd2, id_imm, m_data, w_data, A, B;
  logic        id_use_imm, id_we, m_we, w_we, ex_valid, ex_ready, ex_we;
  logic [2:0]  id_alu_op, ALUOp;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic        e_valid = 0, e_we = 0;
  logic [31:0] e_a = 0, e_b = 0;
  logic [2:0]  e_op = 0;
  logic [4:0]  e_dst = 0;
  int          e_cnt = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.WIDTH(32), .RA_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_dst(id_dst), .id_we(id_we),
    .m_we(m_we), .m_addr(m_addr), .m_data(m_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .ex_dst(ex_dst), .ex_we(ex_we),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bypass rule: r0 is zero, MEM beats WB, else register file.
  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'd0;
    if (m_we && m_addr == a) return m_data;
    if (w_we && w_addr == a) return w_data;
    return rf;
  endfunction

  // One clock: predict next state from current inputs, advance, compare.
  task automatic tick();
    logic rdy;
    int   ncnt;
    #1;
    rdy = !e_valid || ex_ready;
    chk("id_ready", id_ready, rdy);
    ncnt = (e_valid && !ex_ready) ? ((e_cnt == CMAX) ? e_cnt : e_cnt + 1) : e_cnt;
    if (reset) begin
      e_valid = 0; e_a = 0; e_b = 0; e_op = 0; e_dst = 0; e_we = 0; e_cnt = 0;
    end else begin
      e_cnt = ncnt;
      if (flush || (rdy && !id_valid)) begin
        e_valid = 0; e_a = 0; e_b = 0; e_op = 0; e_dst = 0; e_we = 0;
      end else if (rdy) begin
        e_valid = 1;
        e_a     = ref_fwd(id_rs, id_rd1);
        e_b     = id_use_imm ? id_imm : ref_fwd(id_rt, id_rd2);
        e_op    = id_alu_op;
        e_dst   = id_dst;
        e_we    = id_we && (id_dst != 0);
      end
    end
    @(posedge clk);
    #1;
    chk("ex_valid", ex_valid, e_valid);
    chk("A", A, e_a);
    chk("B", B, e_b);
    chk("ALUOp", ALUOp, e_op);
    chk("ex_dst", ex_dst, e_dst);
    chk("ex_we", ex_we, e_we);
    chk("stall_cnt", stall_cnt, e_cnt);
  endtask

  task automatic idle_inputs();
    reset = 0; flush = 0; id_valid = 0; ex_ready = 1;
    id_rs = 0; id_rt = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_use_imm = 0;
    id_alu_op = 0; id_dst = 0; id_we = 0;
    m_we = 0; m_addr = 0; m_data = 0; w_we = 0; w_addr = 0; w_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [31:0] rd1,
                       input logic [4:0] rt, input logic [31:0] rd2,
                       input logic [2:0] op, input logic [4:0] dst);
    id_valid = 1; id_rs = rs; id_rd1 = rd1; id_rt = rt; id_rd2 = rd2;
    id_alu_op = op; id_dst = dst; id_we = 1; id_use_imm = 0;
  endtask

  initial begin
    idle_inputs();
    // Reset then idle
    reset = 1;
    tick(); tick();
    chk("rst_A_zero", A, 32'd0);
    reset = 0;
    tick(); tick();
    chk("idle_valid", ex_valid, 1'b0);

    // Basic capture, no bypass match
    issue(5'd3, 32'h10, 5'd4, 32'h20, 3'd1, 5'd9);
    tick();
    chk("basic_A", A, 32'h10);
    chk("basic_B", B, 32'h20);

    // MEM beats WB
    issue(5'd5, 32'h1, 5'd6, 32'h2, 3'd2, 5'd0);
    m_we = 1; m_addr = 5'd5; m_data = 32'hAAAA;
    w_we = 1; w_addr = 5'd5; w_data = 32'hBBBB;
    tick();
    chk("fwd_prio_A", A, 32'hAAAA);
    chk("dst0_we", ex_we, 1'b0);
    // Zero register ignores a matching bypass
    id_rs = 5'd0; m_addr = 5'd0;
    tick();
    chk("fwd_zero_A", A, 32'd0);

    // Immediate overrides a bypassed rt
    issue(5'd1, 32'h5, 5'd7, 32'h6, 3'd3, 5'd2);
    id_use_imm = 1; id_imm = 32'hFFFF_FFF0; m_addr = 5'd7; m_data = 32'h1234;
    tick();
    chk("imm_B", B, 32'hFFFF_FFF0);
    m_we = 0; w_we = 0; id_use_imm = 0;

    // Backpressure for 3 cycles with new offers each cycle
    issue(5'd8, 32'h100, 5'd9, 32'h200, 3'd0, 5'd1);
    tick();
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      issue(5'd10 + 5'(i), 32'h300 + i, 5'd11, 32'h400, 3'd4, 5'd3);
      tick();
    end
    chk("bp_A_held", A, 32'h100);
    chk("bp_cnt", stall_cnt, 4'd3);
    ex_ready = 1;
    tick();
    chk("bp_release_A", A, 32'h302);

    // Flush wins over a capture; counter kept
    issue(5'd12, 32'h55, 5'd13, 32'h66, 3'd5, 5'd4);
    flush = 1;
    tick();
    chk("flush_valid", ex_valid, 1'b0);
    chk("flush_cnt", stall_cnt, 4'd3);
    flush = 0;

    // Reset in the middle of a stall
    tick();
    ex_ready = 0;
    tick(); tick();
    reset = 1;
    tick();
    chk("rst_stall_cnt", stall_cnt, 4'd0);
    reset = 0;

    // Saturation, then flush leaves the counter alone
    ex_ready = 1;
    issue(5'd2, 32'h77, 5'd3, 32'h88, 3'd6, 5'd5);
    tick();
    ex_ready = 0;
    for (int i = 0; i < CMAX + 5; i++) tick();
    chk("sat_cnt", stall_cnt, 4'hF);
    flush = 1;
    tick();
    chk("sat_flush_cnt", stall_cnt, 4'hF);
    flush = 0;
    reset = 1;
    tick();
    reset = 0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 63) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      ex_ready   = ($urandom_range(0, 2) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_dst     = 5'($urandom_range(0, 3));
      id_rd1     = $urandom; id_rd2 = $urandom; id_imm = $urandom;
      id_use_imm = 1'($urandom);
      id_alu_op  = 3'($urandom);
      id_we      = 1'($urandom);
      m_we       = 1'($urandom); m_addr = 5'($urandom_range(0, 3)); m_data = $urandom;
      w_we       = 1'($urandom); w_addr = 5'($urandom_range(0, 3)); w_data = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
